dct_coeff_collector: RTL and testbench

//  Output-side counterpart of DCT_Engine: receives the engine's serial IEEE-754 coefficient stream
//  (one word per clk, frame of DCT_POINT words) and buffers it in a 2-bank ping-pong store.
//  Re-emits each completed frame in index order on a valid/ready stream with index and last flag.

---
 rtl/dct_pkg.sv | 9 +
 rtl/dct_coeff_bank.sv | 23 ++
 rtl/dct_coeff_collector.sv | 108 ++++++++++
 tb/tb_dct_coeff_collector.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared DCT datapath constants used by DCT_Engine, its input sequencer and the output collector.
package dct_pkg;
  localparam int DCT_POINT = 16;
  localparam int M         = 23;
  localparam int E         = 8;
  localparam int W         = M + E + 1;
  localparam int IDX_W     = $clog2(DCT_POINT);
  localparam int FCNT_W    = 8;
endpackage

// File: rtl/dct_coeff_bank.sv
// One frame of coefficient storage: single write port, asynchronous read port, no reset on contents.
module dct_coeff_bank #(
  parameter int N  = dct_pkg::DCT_POINT,
  parameter int W  = dct_pkg::W,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dct_coeff_collector.sv
// Collects the serial DCT coefficient stream into a 2-bank ping-pong store and replays each
// completed frame in index order on a valid/ready stream.
module dct_coeff_collector #(
  parameter int DCT_POINT = dct_pkg::DCT_POINT,
  parameter int M         = dct_pkg::M,
  parameter int E         = dct_pkg::E,
  parameter int W         = M + E + 1,
  parameter int IDX_W     = $clog2(DCT_POINT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [W-1:0]              in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  input  logic                      clr_err,
  output logic                      overflow,
  output logic                      frame_err,
  output logic [dct_pkg::FCNT_W-1:0] frame_cnt
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DCT_POINT - 1);

  logic             wr_bank, rd_bank;
  logic [IDX_W-1:0] wr_idx, rd_idx, waddr;
  logic [1:0]       bank_full, bank_full_nxt;
  logic             wr_acc, resync, wr_done, rd_acc, rd_done;
  logic [W-1:0]     rdata [2];

  // Handshakes: a word moves on a port only in a cycle where its valid and ready are both high;
  // ready never depends combinationally on the same port's valid.
  assign in_ready  = !bank_full[wr_bank];
  assign out_valid = bank_full[rd_bank];

  assign wr_acc  = in_valid && in_ready;
  // A start-of-frame mid-frame restarts the bank at index 0, discarding the partial frame.
  assign resync  = wr_acc && in_sof && (wr_idx != '0);
  assign waddr   = resync ? '0 : wr_idx;
  assign wr_done = wr_acc && (waddr == LAST);
  assign rd_acc  = out_valid && out_ready;
  assign rd_done = rd_acc && (rd_idx == LAST);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    dct_coeff_bank #(.N(DCT_POINT), .W(W), .AW(IDX_W)) u_bank (
      .clk   (clk),
      .we    (wr_acc && (wr_bank == 1'(g))),
      .waddr (waddr),
      .wdata (in_data),
      .raddr (rd_idx),
      .rdata (rdata[g])
    );
  end

  assign out_data = rdata[rd_bank];
  assign out_idx  = rd_idx;
  assign out_last = (rd_idx == LAST);

  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_done) bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      bank_full <= 2'b00;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_acc) begin
        if (wr_done) begin
          wr_idx    <= '0;
          wr_bank   <= ~wr_bank;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          wr_idx <= waddr + 1'b1;
        end
      end
      if (rd_acc) begin
        if (rd_done) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
      if (clr_err) begin
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (in_valid && !in_ready) overflow <= 1'b1;
        if (resync) frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dct_coeff_collector.sv
// Randomised bench for dct_coeff_collector against a frame-level queue model of the store.
module tb_dct_coeff_collector;
  localparam int N = 16;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_sof, out_ready, clr_err;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, out_last, overflow, frame_err;
  logic [W-1:0]  out_data;
  logic [3:0]    out_idx;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;

  // Model: part_q = partial frame, m_q = completed words not yet consumed.
  logic [W-1:0] part_q[$];
  logic [W-1:0] m_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [3:0]   obs_idx_q[$];
  logic         obs_last_q[$];
  logic         m_ovf, m_ferr;
  logic [7:0]   m_fcnt;
  int           rdy_mis, vld_mis;

  dct_coeff_collector dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .clr_err(clr_err), .overflow(overflow),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_ready();
    return ((m_q.size() + N - 1) / N) < 2;
  endfunction

  task automatic model_clear();
    part_q.delete(); m_q.delete();
    m_ovf = 1'b0; m_ferr = 1'b0; m_fcnt = 8'd0;
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); obs_idx_q.delete(); obs_last_q.delete();
    rdy_mis = 0; vld_mis = 0;
  endtask

  // One clock: sample at the falling edge, advance the model, return 1 time unit after the rise.
  task automatic tick();
    bit mrdy, mvld;
    @(negedge clk);
    mrdy = model_ready();
    mvld = (m_q.size() != 0);
    if (in_ready !== mrdy) rdy_mis++;
    if (out_valid !== mvld) vld_mis++;
    if (out_valid === 1'b1 && out_ready) begin
      obs_q.push_back(out_data);
      obs_idx_q.push_back(out_idx);
      obs_last_q.push_back(out_last);
    end
    if (mvld && out_ready) exp_q.push_back(m_q.pop_front());
    if (in_valid) begin
      if (mrdy) begin
        if (in_sof && part_q.size() != 0) begin
          m_ferr = 1'b1;
          part_q.delete();
        end
        part_q.push_back(in_data);
        if (part_q.size() == N) begin
          foreach (part_q[i]) m_q.push_back(part_q[i]);
          part_q.delete();
          m_fcnt = m_fcnt + 8'd1;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (clr_err) begin
      m_ovf = 1'b0; m_ferr = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", overflow, frame_err); end
    @(posedge clk); #1 reset = 1'b1;
    model_clear();
  endtask

  task automatic test_single_frame();
    logic [W-1:0] words[N];
    words[0] = 32'h41200000; words[1] = 32'h41A00000; words[2] = 32'h00000000; words[3] = 32'hC0A00000;
    for (int i = 4; i < N - 1; i++) words[i] = $urandom;
    words[N-1] = 32'h41A80000;
    clear_sb();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = words[i];
      tick();
    end
    idle_inputs();
    checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0) begin errors++; $display("FAIL single_latency got v=%b idx=%0d want v=1 idx=0", out_valid, out_idx); end
    repeat (20) tick();
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL single_count got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_q[i] !== words[i] || obs_idx_q[i] !== 4'(i) || obs_last_q[i] !== (i == N - 1)) begin
        errors++;
        $display("FAIL single_word[%0d] got %h/%0d/%b want %h/%0d/%b", i, obs_q[i], obs_idx_q[i], obs_last_q[i], words[i], i, i == N - 1);
      end
    end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow got %b want 0", overflow); end
    checks++; if (rdy_mis != 0 || vld_mis != 0) begin errors++; $display("FAIL single_handshake got rdy_mis=%0d vld_mis=%0d want 0/0", rdy_mis, vld_mis); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] sent[3*N];
    logic [7:0] fc0;
    clear_sb();
    fc0 = frame_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      sent[i] = $urandom;
      in_valid = 1'b1; in_sof = (i % N == 0); in_data = sent[i];
      tick();
    end
    idle_inputs();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready got %b want 0", in_ready); end
    checks++; if (frame_cnt !== fc0 + 8'd2) begin errors++; $display("FAIL ovf_frame_cnt got %0d want %0d", frame_cnt, fc0 + 8'd2); end
    out_ready = 1'b1;
    repeat (40) tick();
    checks++; if (obs_q.size() != 2 * N) begin errors++; $display("FAIL ovf_count got %0d want %0d", obs_q.size(), 2 * N); end
    for (int i = 0; i < 2 * N; i++) begin
      checks++;
      if (obs_q[i] !== sent[i] || obs_idx_q[i] !== 4'(i % N)) begin
        errors++; $display("FAIL ovf_word[%0d] got %h/%0d want %h/%0d", i, obs_q[i], obs_idx_q[i], sent[i], i % N);
      end
    end
    checks++; if (rdy_mis != 0 || vld_mis != 0) begin errors++; $display("FAIL ovf_handshake got rdy_mis=%0d vld_mis=%0d want 0/0", rdy_mis, vld_mis); end
  endtask

  task automatic test_toggle_ready();
    logic [W-1:0] sent[$];
    int acc, cyc;
    bit mr;
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b want 0", overflow); end
    clear_sb();
    acc = 0; cyc = 0;
    while (acc < 4 * N && cyc < 500) begin
      mr = model_ready();
      in_valid = mr; in_sof = mr && (acc % N == 0); in_data = $urandom;
      out_ready = cyc[0];
      if (mr) sent.push_back(in_data);
      tick();
      if (mr) acc++;
      cyc++;
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (50) tick();
    checks++; if (acc != 4 * N) begin errors++; $display("FAIL toggle_timeout got %0d words want %0d", acc, 4 * N); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL toggle_overflow got %b want 0", overflow); end
    checks++; if (obs_q.size() != sent.size()) begin errors++; $display("FAIL toggle_count got %0d want %0d", obs_q.size(), sent.size()); end
    foreach (sent[i]) begin
      checks++;
      if (obs_q[i] !== sent[i] || obs_idx_q[i] !== 4'(i % N)) begin
        errors++; $display("FAIL toggle_word[%0d] got %h/%0d want %h/%0d", i, obs_q[i], obs_idx_q[i], sent[i], i % N);
      end
    end
    checks++; if (rdy_mis != 0 || vld_mis != 0) begin errors++; $display("FAIL toggle_handshake got rdy_mis=%0d vld_mis=%0d want 0/0", rdy_mis, vld_mis); end
  endtask

  task automatic test_frame_err();
    logic [W-1:0] frame[N];
    clear_sb();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = $urandom;
      tick();
    end
    for (int i = 0; i < N; i++) begin
      frame[i] = $urandom;
      in_valid = 1'b1; in_sof = (i == 0); in_data = frame[i];
      tick();
    end
    idle_inputs();
    repeat (20) tick();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ferr_overflow got %b want 0", overflow); end
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL ferr_count got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_q[i] !== frame[i] || obs_idx_q[i] !== 4'(i)) begin
        errors++; $display("FAIL ferr_word[%0d] got %h/%0d want %h/%0d", i, obs_q[i], obs_idx_q[i], frame[i], i);
      end
    end
    checks++; if (frame_cnt !== m_fcnt) begin errors++; $display("FAIL ferr_frame_cnt got %0d want %0d", frame_cnt, m_fcnt); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear got %b want 0", frame_err); end
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] words[N];
    int c;
    clear_sb();
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = $urandom;
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    c = 0;
    while (!(out_valid === 1'b1 && out_idx === 4'd7) && c < 40) begin
      tick(); c++;
    end
    checks++; if (c >= 40) begin errors++; $display("FAIL drain_reach_idx7 got timeout want idx 7"); end
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL midrst_out_last got %b want 0", out_last); end
    #1 reset = 1'b1;
    model_clear();
    clear_sb();
    for (int i = 0; i < N; i++) begin
      words[i] = $urandom;
      in_valid = 1'b1; in_sof = (i == 0); in_data = words[i];
      tick();
    end
    idle_inputs();
    repeat (20) tick();
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL post_rst_count got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_q[i] !== words[i] || obs_last_q[i] !== (i == N - 1)) begin
        errors++; $display("FAIL post_rst_word[%0d] got %h/%b want %h/%b", i, obs_q[i], obs_last_q[i], words[i], i == N - 1);
      end
    end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL post_rst_frame_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_wrap();
    int bad;
    apply_reset();
    clear_sb();
    out_ready = 1'b1;
    for (int f = 0; f < 256; f++) begin
      if (f == 255) begin
        checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_cnt255 got %0d want 255", frame_cnt); end
      end
      for (int k = 0; k < N; k++) begin
        in_valid = 1'b1; in_sof = (k == 0); in_data = $urandom;
        tick();
      end
    end
    idle_inputs();
    repeat (20) tick();
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got %0d want 0", frame_cnt); end
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL wrap_flags got %b%b want 00", overflow, frame_err); end
    checks++; if (obs_q.size() != 256 * N || exp_q.size() != 256 * N) begin errors++; $display("FAIL wrap_count got %0d want %0d", obs_q.size(), 256 * N); end
    bad = 0;
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i] || obs_idx_q[i] !== 4'(i % N)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_words got %0d bad words want 0", bad); end
    checks++; if (rdy_mis != 0 || vld_mis != 0) begin errors++; $display("FAIL wrap_handshake got rdy_mis=%0d vld_mis=%0d want 0/0", rdy_mis, vld_mis); end
  endtask

  initial begin
    model_clear();
    clear_sb();
    test_reset();
    test_single_frame();
    test_overflow();
    test_toggle_ready();
    test_frame_err();
    test_reset_mid_drain();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
